fetch_queue: RTL and testbench

//  Dual-lane instruction queue between fetch stage 2 and decode. Accepts 0-2 fetch_data_t per cycle and

---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fetch_compact.sv | 14 +
 rtl/fetch_queue.sv | 65 ++++++
 tb/tb_fetch_queue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared types and constants for the fetch-to-decode queue.
package fetch_queue_pkg;
  localparam int FQ_DEPTH = 8;
  localparam int FQ_PW = $clog2(FQ_DEPTH) + 1;
  typedef logic [FQ_PW-1:0] fq_ptr_t;
  localparam logic [1:0] DEQ_0 = 2'd0;
  localparam logic [1:0] DEQ_1 = 2'd1;
  localparam logic [1:0] DEQ_2 = 2'd2;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data_t;
endpackage

// File: rtl/fetch_compact.sv
// fetch_compact: packs valid fetch lanes older-first and counts them.
module fetch_compact
  import fetch_queue_pkg::*;
(
  input  fetch_data_t [1:0] in_data,
  output fetch_data_t [1:0] cdata,
  output logic [1:0]        n_enq
);
  always_comb begin
    cdata[1] = in_data[1].valid ? in_data[1] : in_data[0].valid ? in_data[0] : '0;
    cdata[0] = (in_data[1].valid && in_data[0].valid) ? in_data[0] : '0;
    n_enq = 2'(in_data[1].valid) + 2'(in_data[0].valid);
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: dual-lane fetch-to-decode instruction queue.
// Define FETCH_QUEUE_BYPASS_EN for same-cycle input-to-output bypass.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  fetch_data_t [1:0]      in_data,
  output logic                   in_ready,
  input  logic [1:0]             deq_num,
  output fetch_data_t [1:0]      out_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] head, tail, head1, tail1, vis;
  logic [1:0] n_enq, n_avail, src, n_deq, n_head, skip, n_wr;
  fetch_data_t [1:0] cdata;
  fetch_data_t mem [DEPTH];
  fetch_compact u_compact (.in_data(in_data), .cdata(cdata), .n_enq(n_enq));
  assign count = tail - head;
  assign head1 = head + PW'(1);
  assign tail1 = tail + PW'(1);
  assign in_ready = count <= PW'(DEPTH - 2);
  // Visible stream = stored entries followed by any bypassed input lanes;
  // dequeue eats from its front, skip = input lanes consumed before storage.
  always_comb begin
    n_avail = in_ready ? n_enq : 2'd0;
`ifdef FETCH_QUEUE_BYPASS_EN
    src = flush ? 2'd0 : n_avail;
`else
    src = 2'd0;
`endif
    vis = count + PW'(src);
    n_deq = deq_num > DEQ_2 ? DEQ_2 : deq_num;
    n_deq = vis < PW'(n_deq) ? vis[1:0] : n_deq;
    n_head = count < PW'(n_deq) ? count[1:0] : n_deq;
    skip = n_deq - n_head;
    n_wr = n_avail - skip;
    out_data[1] = count >= PW'(1) ? mem[head[AW-1:0]] : src >= 2'd1 ? cdata[1] : '0;
    out_data[0] = count >= PW'(2) ? mem[head1[AW-1:0]] :
                  count == PW'(1) ? (src >= 2'd1 ? cdata[1] : '0) :
                  (src >= 2'd2 ? cdata[0] : '0);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + PW'(n_head);
      tail <= tail + PW'(n_wr);
    end
  always_ff @(posedge clk)
    if (!flush && n_wr != 2'd0) begin
      mem[tail[AW-1:0]] <= skip == 2'd0 ? cdata[1] : cdata[0];
      if (n_wr == 2'd2) mem[tail1[AW-1:0]] <= cdata[0];
    end
  a_deq_legal: assert property (@(posedge clk) disable iff (reset || flush) PW'(deq_num) <= vis);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: queue-model scoreboard plus directed literal checks for fetch_queue.
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  localparam int DEPTH = 8;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_ready;
  logic [1:0] deq_num = 2'd0;
  logic [3:0] count;
  fetch_data_t [1:0] in_data = '0, out_data;
  int checks = 0, failures = 0;
  logic [31:0] q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_ready(in_ready),
    .deq_num(deq_num), .out_data(out_data), .count(count));

  always #5 clk = ~clk;

  function automatic fetch_data_t ent(input logic [31:0] pc);
    ent.valid = 1'b1;
    ent.pc = pc;
    ent.instr = ~pc;
  endfunction

  task automatic check(input string nm, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: FIFO of pcs; bypass build lets decode consume the incoming bundle too.
  always @(posedge clk or posedge reset) begin : mdl
    logic [31:0] ins[$];
    int nd;
    ins.delete();
    if (reset || flush) q.delete();
    else begin
      if ((DEPTH - q.size()) >= 2) begin
        if (in_data[1].valid) ins.push_back(in_data[1].pc);
        if (in_data[0].valid) ins.push_back(in_data[0].pc);
      end
      if (BYP) q = {q, ins};
      nd = int'(deq_num);
      if (nd > q.size()) nd = q.size();
      repeat (nd) void'(q.pop_front());
      if (!BYP) q = {q, ins};
    end
  end

  always @(negedge clk) begin : cmp
    logic [31:0] v[$];
    fetch_data_t e1, e0;
    if (!reset) begin
      v = q;
      if (BYP && !flush && (DEPTH - q.size()) >= 2) begin
        if (in_data[1].valid) v.push_back(in_data[1].pc);
        if (in_data[0].valid) v.push_back(in_data[0].pc);
      end
      e1 = '0;
      e0 = '0;
      if (v.size() >= 1) e1 = ent(v[0]);
      if (v.size() >= 2) e0 = ent(v[1]);
      check("count", 96'(count), 96'(q.size()));
      check("in_ready", 96'(in_ready), 96'((DEPTH - q.size()) >= 2));
      check("lane1", 96'(out_data[1]), 96'(e1));
      check("lane0", 96'(out_data[0]), 96'(e0));
    end
  end

  task automatic step(input logic v1, input logic [31:0] p1, input logic v0,
                      input logic [31:0] p0, input logic [1:0] d, input logic f);
    in_data[1] = '{valid: v1, pc: p1, instr: ~p1};
    in_data[0] = '{valid: v0, pc: p0, instr: ~p0};
    deq_num = d;
    flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_data = '0;
    deq_num = 2'd0;
    flush = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_v1", 96'(out_data[1].valid), 96'(0));
    check("rst_v0", 96'(out_data[0].valid), 96'(0));
    check("rst_ready", 96'(in_ready), 96'(1));
    check("rst_count", 96'(count), 96'(0));
    // async reset mid-fill
    step(1, 32'h80, 1, 32'h84, 0, 0);
    step(1, 32'h88, 1, 32'h8c, 0, 0);
    step(1, 32'h90, 0, 32'h0, 0, 0);
    idle();
    #1 check("fill5_count", 96'(count), 96'(5));
    #2 reset = 1'b1;
    #1;
    check("async_count", 96'(count), 96'(0));
    check("async_v1", 96'(out_data[1].valid), 96'(0));
    check("async_v0", 96'(out_data[0].valid), 96'(0));
    check("async_ready", 96'(in_ready), 96'(1));
    @(posedge clk);
    #1 reset = 1'b0;
    // both lanes
    step(1, 32'h10, 1, 32'h14, 0, 0);
    idle();
    #1;
    check("dual_pc1", 96'(out_data[1].pc), 96'h10);
    check("dual_pc0", 96'(out_data[0].pc), 96'h14);
    check("dual_count", 96'(count), 96'(2));
    step(0, 0, 0, 0, 2, 0);
    // lane [0] only
    step(0, 32'h0, 1, 32'h20, 0, 0);
    idle();
    #1;
    check("single_pc1", 96'(out_data[1].pc), 96'h20);
    check("single_v0", 96'(out_data[0].valid), 96'(0));
    check("single_count", 96'(count), 96'(1));
    step(0, 0, 0, 0, 1, 0);
    // fill, hold, drain
    for (int k = 0; k < 4; k++) step(1, 32'h100 + 8 * k, 1, 32'h104 + 8 * k, 0, 0);
    idle();
    #1;
    check("full_ready", 96'(in_ready), 96'(0));
    check("full_count", 96'(count), 96'(8));
    repeat (2) step(1, 32'h200, 1, 32'h204, 0, 0);
    step(1, 32'h200, 1, 32'h204, 2, 0);
    check("held_count6", 96'(count), 96'(6));
    step(1, 32'h200, 1, 32'h204, 0, 0);
    idle();
    #1;
    check("held_count8", 96'(count), 96'(8));
    check("held_head", 96'(out_data[1].pc), 96'h108);
    step(1, 32'h300, 1, 32'h304, 1, 0);
    idle();
    #1;
    check("c7_ready", 96'(in_ready), 96'(0));
    check("c7_count", 96'(count), 96'(7));
    check("c7_head", 96'(out_data[1].pc), 96'h10c);
    repeat (3) step(0, 0, 0, 0, 2, 0);
    step(0, 0, 0, 0, 1, 0);
    check("drained", 96'(count), 96'(0));
    // wrap streaming
    for (int k = 0; k < 20; k++) begin
      step(1, 32'(8 * k), 1, 32'(8 * k + 4), (k == 0) ? 2'd0 : 2'd2, 0);
      check("wrap_pc1", 96'(out_data[1].pc), 96'(8 * k));
      check("wrap_pc0", 96'(out_data[0].pc), 96'(8 * k + 4));
      check("wrap_count", 96'(count), 96'(2));
    end
    step(0, 0, 0, 0, 2, 0);
    // flush with concurrent push and dequeue
    for (int k = 0; k < 3; k++) step(1, 32'h400 + 8 * k, 1, 32'h404 + 8 * k, 0, 0);
    step(1, 32'h500, 1, 32'h504, 2, 1);
    idle();
    #1;
    check("flush_count", 96'(count), 96'(0));
    check("flush_v1", 96'(out_data[1].valid), 96'(0));
    check("flush_v0", 96'(out_data[0].valid), 96'(0));
    step(1, 32'h600, 0, 32'h0, 0, 0);
    idle();
    #1;
    check("post_flush_pc1", 96'(out_data[1].pc), 96'h600);
    check("post_flush_count", 96'(count), 96'(1));
    step(0, 0, 0, 0, 1, 0);
    // same-cycle visibility
    in_data[1] = ent(32'h40);
    in_data[0] = ent(32'h44);
    deq_num = BYP ? 2'd2 : 2'd0;
    #2;
    check("same_v1", 96'(out_data[1].valid), 96'(BYP));
    check("same_pc0", 96'(out_data[0].pc), BYP ? 96'h44 : 96'h0);
    @(posedge clk);
    #1;
    idle();
    #1;
    check("same_count", 96'(count), BYP ? 96'(0) : 96'(2));
    if (!BYP) step(0, 0, 0, 0, 2, 0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
